// File: rtl/imm_extender_pipe_pkg.sv
// imm_extender_pipe_pkg
//   Shared definitions for the immediate extender and for the decoder that
//   drives it: the extension-mode field width and its encodings.
package imm_extender_pipe_pkg;

  localparam int IMM_MODE_W = 2;

  typedef enum logic [IMM_MODE_W-1:0] {
    IMM_ZEXT     = 2'd0,
    IMM_SEXT     = 2'd1,
    IMM_SEXT_SHL = 2'd2,
    IMM_UPPER    = 2'd3
  } imm_mode_e;

endpackage

// File: rtl/imm_extender_pipe_core.sv
// imm_ext_core
//   Purely combinational immediate widener.
//   imm  [IN_W]   raw immediate
//   mode [2]      ZEXT / SEXT / SEXT_SHL / UPPER
//   data [OUT_W]  extended result
//   ovf           (only with IMM_EXT_OVF_EN) SEXT_SHL lost significant bits
module imm_ext_core
  import imm_extender_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic [IN_W-1:0]       imm,
  input  logic [IMM_MODE_W-1:0] mode,
`ifdef IMM_EXT_OVF_EN
  output logic                  ovf,
`endif
  output logic [OUT_W-1:0]      data
);

  logic [OUT_W-1:0] zx, sx;

  always_comb begin
    // Built by overlay rather than replication so IN_W == OUT_W stays legal.
    zx             = '0;
    zx[IN_W-1:0]   = imm;
    sx             = {OUT_W{imm[IN_W-1]}};
    sx[IN_W-1:0]   = imm;
    unique case (imm_mode_e'(mode))
      IMM_ZEXT:     data = zx;
      IMM_SEXT:     data = sx;
      IMM_SEXT_SHL: data = sx << SHIFT;
      IMM_UPPER:    data = zx << (OUT_W - IN_W);
      default:      data = zx;
    endcase
  end

`ifdef IMM_EXT_OVF_EN
  // The SHIFT bits pushed out the top must all match the new sign bit,
  // which is sx[OUT_W-1-SHIFT] before the shift.
  always_comb begin
    ovf = 1'b0;
    if (imm_mode_e'(mode) == IMM_SEXT_SHL) begin
      for (int i = 0; i < SHIFT; i++) begin
        if (sx[OUT_W-1-i] != sx[OUT_W-1-SHIFT]) ovf = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/imm_extender_pipe.sv
// imm_extender_pipe
//   Pipelined immediate extender between decode and the ALU operand mux.
//   The extension is computed at accept and stored in a 2-entry FIFO, so a
//   result is visible the cycle after accept; no comb path in_* -> out_*.
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  upstream handshake; in_imm [IN_W], in_mode [2]
//   out_valid/ready downstream handshake; out_data [OUT_W]
//   out_ovf         only when IMM_EXT_OVF_EN is defined
module imm_extender_pipe
  import imm_extender_pipe_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_imm,
  input  logic [IMM_MODE_W-1:0] in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef IMM_EXT_OVF_EN
  output logic                  out_ovf,
`endif
  output logic [OUT_W-1:0]      out_data
);

  logic [OUT_W-1:0] ext_data;
  logic             acc, pop;

  logic [1:0][OUT_W-1:0] mem_q, mem_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
`ifdef IMM_EXT_OVF_EN
  logic                  ext_ovf;
  logic [1:0]            ovf_q, ovf_d;
`endif

  imm_ext_core #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_core (
    .imm  (in_imm),
    .mode (in_mode),
`ifdef IMM_EXT_OVF_EN
    .ovf  (ext_ovf),
`endif
    .data (ext_data)
  );

  // Ready comes from the count only, never from out_ready, so a full buffer
  // reopens one cycle after a pop.
  assign in_ready  = !rst && (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
`ifdef IMM_EXT_OVF_EN
  assign out_ovf   = ovf_q[rd_ptr_q];
`endif

  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
`ifdef IMM_EXT_OVF_EN
    ovf_d    = ovf_q;
`endif
    if (acc) begin
      mem_d[wr_ptr_q] = ext_data;
`ifdef IMM_EXT_OVF_EN
      ovf_d[wr_ptr_q] = ext_ovf;
`endif
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    unique case ({acc, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is cleared too so out_data reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
`ifdef IMM_EXT_OVF_EN
      ovf_q    <= '0;
`endif
    end else begin
      mem_q    <= mem_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
`ifdef IMM_EXT_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_imm_extender_pipe.sv
// tb_imm_extender_pipe
//   Scoreboard bench: main instance at 16->32 SHIFT=2, plus 16->16 SHIFT=2
//   and 8->8 SHIFT=0 instances for the width-edge cases.
module tb_imm_extender_pipe;
  import imm_extender_pipe_pkg::*;

  localparam int IN_W = 16, OUT_W = 32, SHIFT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance
  logic             in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [IN_W-1:0]  in_imm = '0;
  logic [1:0]       in_mode = '0;
  logic [OUT_W-1:0] out_data;
  // 16 -> 16, SHIFT 2
  logic             vb = 1'b0, rb, ovb;
  logic [15:0]      ib = '0, db;
  logic [1:0]       mb = '0;
  // 8 -> 8, SHIFT 0
  logic             vc = 1'b0, rc, ovc;
  logic [7:0]       ic = '0, dc;
  logic [1:0]       mc = '0;
`ifdef IMM_EXT_OVF_EN
  logic             out_ovf, ovf_b, ovf_c;
`endif

  imm_extender_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef IMM_EXT_OVF_EN
    .out_ovf(out_ovf),
`endif
    .out_data(out_data));

  imm_extender_pipe #(.IN_W(16), .OUT_W(16), .SHIFT(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(vb), .in_ready(rb), .in_imm(ib),
    .in_mode(mb), .out_valid(ovb), .out_ready(1'b1),
`ifdef IMM_EXT_OVF_EN
    .out_ovf(ovf_b),
`endif
    .out_data(db));

  imm_extender_pipe #(.IN_W(8), .OUT_W(8), .SHIFT(0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(vc), .in_ready(rc), .in_imm(ic),
    .in_mode(mc), .out_valid(ovc), .out_ready(1'b1),
`ifdef IMM_EXT_OVF_EN
    .out_ovf(ovf_c),
`endif
    .out_data(dc));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model in 64-bit signed arithmetic.
  function automatic void model(input logic [IN_W-1:0] imm, input logic [1:0] mode,
                                output logic [OUT_W-1:0] d, output logic o);
    logic signed [IN_W-1:0] si;
    longint s, sh, top, u;
    si = imm; s = si; u = longint'(imm); o = 1'b0;
    case (mode)
      2'd0: d = OUT_W'(u);
      2'd1: d = OUT_W'(s);
      2'd2: begin
        sh  = s <<< SHIFT;
        d   = OUT_W'(sh);
        top = sh >>> (OUT_W - 1);
        o   = !(top == 0 || top == -1);
      end
      default: d = OUT_W'(u << (OUT_W - IN_W));
    endcase
  endfunction

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             ovf;
    int               acc;
    bit               lat;
  } exp_t;
  exp_t sb[$];

  // Pops happen at the next posedge; compare against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", 64'(out_data), 64'hDEAD);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", 64'(out_data), 64'(e.data));
`ifdef IMM_EXT_OVF_EN
        chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
`endif
        if (e.lat) chk("latency", 64'(cyc), 64'(e.acc));
      end
    end
  end

  task automatic push(input logic [IN_W-1:0] imm, input logic [1:0] mode, input bit lat,
                      output int acc, output int waits);
    exp_t e;
    model(imm, mode, e.data, e.ovf);
    e.lat = lat;
    in_valid = 1'b1; in_imm = imm; in_mode = mode; waits = 0; acc = -1;
    @(negedge clk);
    while (!in_ready && waits < 50) begin waits++; @(negedge clk); end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc = cyc; e.acc = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic aux_b(input logic [15:0] imm, input logic [1:0] mode,
                       input logic [15:0] ed, input logic eo);
    vb = 1'b1; ib = imm; mb = mode;
    @(negedge clk); chk("b_in_ready", 64'(rb), 64'd1);
    @(posedge clk); #1; vb = 1'b0;
    @(negedge clk);
    chk("b_out_valid", 64'(ovb), 64'd1);
    chk("b_out_data", 64'(db), 64'(ed));
`ifdef IMM_EXT_OVF_EN
    chk("b_out_ovf", 64'(ovf_b), 64'(eo));
`else
    if (eo === 1'bx) chk("b_exp_ovf_known", 64'(eo), 64'd0);
`endif
    @(posedge clk); #1;
  endtask

  task automatic aux_c(input logic [1:0] mode);
    vc = 1'b1; ic = 8'h80; mc = mode;
    @(negedge clk); chk("c_in_ready", 64'(rc), 64'd1);
    @(posedge clk); #1; vc = 1'b0;
    @(negedge clk);
    chk("c_out_valid", 64'(ovc), 64'd1);
    chk("c_out_data", 64'(dc), 64'h80);
`ifdef IMM_EXT_OVF_EN
    chk("c_out_ovf", 64'(ovf_c), 64'd0);
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, waits, r;
    logic [IN_W-1:0] imm;
    logic [1:0] mode;

    // reset state
    idle(3);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // 1: one item per cycle, out_ready high
    out_ready = 1'b1;
    push(16'h8001, 2'd0, 1'b1, acc, waits); chk("t1_wait0", 64'(waits), 64'd0);
    push(16'h8001, 2'd1, 1'b1, acc, waits); chk("t1_wait1", 64'(waits), 64'd0);
    push(16'hFFFF, 2'd2, 1'b1, acc, waits); chk("t1_wait2", 64'(waits), 64'd0);
    push(16'h1234, 2'd3, 1'b1, acc, waits); chk("t1_wait3", 64'(waits), 64'd0);
    idle(3);
    chk("t1_drained", 64'(sb.size()), 64'd0);

    // 2: backpressure
    out_ready = 1'b0;
    push(16'h0001, 2'd1, 1'b0, acc, waits);
    push(16'h0002, 2'd1, 1'b0, acc, waits);
    in_valid = 1'b1; in_imm = 16'h0003; in_mode = 2'd1;
    repeat (3) begin
      @(negedge clk);
      chk("t2_full_in_ready", 64'(in_ready), 64'd0);
      chk("t2_hold_valid", 64'(out_valid), 64'd1);
      chk("t2_hold_data", 64'(out_data), 64'h1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; r = cyc;
    push(16'h0003, 2'd1, 1'b0, acc, waits);
    chk("t2_c_accept_cycle", 64'(acc), 64'(r + 2));
    idle(4);
    chk("t2_drained", 64'(sb.size()), 64'd0);

    // 3: steady push/pop at count 1
    for (int i = 0; i < 11; i++) begin
      imm  = IN_W'($urandom);
      mode = 2'($urandom_range(0, 3));
      push(imm, mode, 1'b1, acc, waits);
      chk("t3_no_bubble", 64'(waits), 64'd0);
    end
    idle(3);
    chk("t3_drained", 64'(sb.size()), 64'd0);

    // 4: reset while full; concurrent handshakes must be ignored
    out_ready = 1'b0;
    push(16'h1111, 2'd1, 1'b0, acc, waits);
    push(16'h2222, 2'd1, 1'b0, acc, waits);
    rst = 1'b1; in_valid = 1'b1; in_imm = 16'h5555; out_ready = 1'b1;
    @(negedge clk);
    chk("t4_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("t4_out_valid", 64'(out_valid), 64'd0);
    chk("t4_out_data", 64'(out_data), 64'd0);
    chk("t4_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    push(16'h7FFF, 2'd1, 1'b1, acc, waits);
    idle(3);
    chk("t4_drained", 64'(sb.size()), 64'd0);

    // 5: 16 -> 16, SHIFT 2
    aux_b(16'h4000, 2'd2, 16'h0000, 1'b1);
    aux_b(16'hE000, 2'd2, 16'h8000, 1'b0);
    aux_b(16'h4000, 2'd1, 16'h4000, 1'b0);

    // 6: 8 -> 8, SHIFT 0, every mode passes through
    for (int m = 0; m < 4; m++) aux_c(2'(m));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
